bayer_gray_stream: RTL



---
 rtl/bayer_gray_pkg.sv | 38 +++
 rtl/gray_line_buf.sv | 42 ++++
 rtl/bayer_gray_stream.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bayer_gray_pkg.sv
// ---------------------------------------------------------------------------
// bayer_gray_pkg
//
// Shared constants and types for the Bayer-to-grayscale stream converter.
//
// Contents:
//   RAW_W_DEF / RAW_H_DEF / DW_DEF  default raw frame geometry and sample width
//   OUT_W / OUT_H                   output (quad) frame geometry for the defaults
//   PAIR_W / QUAD_W                 widths of a 2-sample and a 4-sample sum
//   COORD_W                         width of the oX / oY output coordinates
//   state_t + ST_* constants        frame-tracking FSM encoding
//
// Optional build macro used by the top: GRAY_MIRROR_EN (mirrored oX).
// ---------------------------------------------------------------------------
package bayer_gray_pkg;

    localparam int RAW_W_DEF = 1280;
    localparam int RAW_H_DEF = 960;
    localparam int DW_DEF    = 12;

    localparam int OUT_W     = RAW_W_DEF / 2;
    localparam int OUT_H     = RAW_H_DEF / 2;

    // One extra bit holds the sum of two samples, two extra bits hold four.
    localparam int PAIR_W    = DW_DEF + 1;
    localparam int QUAD_W    = DW_DEF + 2;

    localparam int COORD_W   = 10;

    // Plain logic constants rather than an enum so the encoding stays
    // visible to older tooling that probes the state register directly.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/gray_line_buf.sv
// ---------------------------------------------------------------------------
// gray_line_buf
//
// Single-port synchronous RAM holding one raw row worth of horizontal
// pair-sums. A cycle performs either a write or a read, never both; the
// caller guarantees this (writes happen on even raw rows, reads on odd).
//
// Ports:
//   iCLK   clock
//   we     write enable (wdata -> mem[addr])
//   re     read enable (mem[addr] -> rdata on the next cycle)
//   addr   word address, 0 .. DEPTH-1
//   wdata  pair-sum to store
//   rdata  registered read data; holds its value until the next read
// ---------------------------------------------------------------------------
module gray_line_buf #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int WIDTH = 13
) (
    input  logic             iCLK,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read data is only updated on a read, so a value fetched on an even
    // column survives any number of idle cycles before the odd column uses it.
    // No reset: the contents are always rewritten before they are read.
    always_ff @(posedge iCLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bayer_gray_stream.sv
// ---------------------------------------------------------------------------
// bayer_gray_stream
//
// Converts a raw RAW_W x RAW_H Bayer stream into a (RAW_W/2) x (RAW_H/2)
// grayscale stream. Every non-overlapping 2x2 quad becomes one pixel equal
// to the truncated mean of its four samples. Horizontal pair-sums of the
// even raw row are parked in a line buffer and combined with the odd row.
//
// Ports:
//   iCLK         clock
//   iRST         synchronous active-high reset
//   iFVAL        frame valid; a rising edge starts a frame, a fall aborts it
//   iDVAL        raw sample valid, one sample per asserted cycle
//   iDATA        raw Bayer sample (DW bits)
//   oDVAL        one-cycle gray pixel strobe
//   oX, oY       output pixel coordinates
//   oGRAY        gray value (DW bits)
//   oFRAME_DONE  pulses together with the last pixel of a complete frame
//
// Build option:
//   GRAY_MIRROR_EN  when defined, oX is reported mirrored (OUT_W-1 - column);
//                   emission order and timing are unchanged.
// ---------------------------------------------------------------------------
module bayer_gray_stream
    import bayer_gray_pkg::*;
#(
    parameter int RAW_W = RAW_W_DEF,
    parameter int RAW_H = RAW_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [DW-1:0]      iDATA,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic [DW-1:0]      oGRAY,
    output logic               oFRAME_DONE
);

    localparam int COLS = RAW_W / 2;
    localparam int XW   = $clog2(RAW_W);
    localparam int YW   = $clog2(RAW_H);
    localparam int AW   = (COLS > 1) ? $clog2(COLS) : 1;

    state_t          state;
    logic            fval_d;
    logic [XW-1:0]   rx;
    logic [YW-1:0]   ry;
    logic [DW-1:0]   pair;
    logic [DW:0]     buf_rdata;

    logic            beat;
    logic            col_odd;
    logic            row_odd;
    logic            last_col;
    logic            last_row;
    logic            buf_we;
    logic            buf_re;
    logic [AW-1:0]   buf_addr;
    logic [DW:0]     pair_sum;
    logic [DW+1:0]   quad_sum;
    logic [COORD_W-1:0] qx_out;
    logic [COORD_W-1:0] qy_out;

    // Decode the current raw position and build the datapath sums. A sample
    // only counts while the frame is active and iFVAL is still high; a
    // sample arriving in the same cycle iFVAL falls belongs to the aborted
    // frame and is dropped.
    always_comb begin
        beat     = (state == ST_ACTIVE) && iFVAL && iDVAL;
        col_odd  = rx[0];
        row_odd  = ry[0];
        last_col = (rx == XW'(RAW_W - 1));
        last_row = (ry == YW'(RAW_H - 1));

        buf_we   = beat && !row_odd &&  col_odd;
        buf_re   = beat &&  row_odd && !col_odd;
        buf_addr = AW'(rx >> 1);

        pair_sum = {1'b0, pair} + {1'b0, iDATA};
        quad_sum = {1'b0, buf_rdata} + {2'b00, pair} + {2'b00, iDATA};

`ifdef GRAY_MIRROR_EN
        qx_out   = COORD_W'(COLS - 1) - COORD_W'(rx >> 1);
`else
        qx_out   = COORD_W'(rx >> 1);
`endif
        qy_out   = COORD_W'(ry >> 1);
    end

    gray_line_buf #(
        .DEPTH (COLS),
        .AW    (AW),
        .WIDTH (DW + 1)
    ) u_line_buf (
        .iCLK  (iCLK),
        .we    (buf_we),
        .re    (buf_re),
        .addr  (buf_addr),
        .wdata (pair_sum),
        .rdata (buf_rdata)
    );

    // Frame tracking, raw counters and the registered output stage.
    // fval_d resets high so that a reset in the middle of a frame (iFVAL
    // still asserted) does not look like a fresh rising edge; the next frame
    // only starts after iFVAL has been seen low and then high again. The
    // same edge detector keeps DONE -> IDLE from restarting on a frame valid
    // that simply stayed high.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= ST_IDLE;
            fval_d      <= 1'b1;
            rx          <= '0;
            ry          <= '0;
            pair        <= '0;
            oDVAL       <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oGRAY       <= '0;
            oFRAME_DONE <= 1'b0;
        end else begin
            fval_d      <= iFVAL;
            oDVAL       <= 1'b0;
            oFRAME_DONE <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (iFVAL && !fval_d) begin
                        state <= ST_ACTIVE;
                        rx    <= '0;
                        ry    <= '0;
                    end
                end

                ST_ACTIVE: begin
                    if (!iFVAL) begin
                        state <= ST_IDLE;
                        rx    <= '0;
                        ry    <= '0;
                        pair  <= '0;
                    end else if (iDVAL) begin
                        if (!col_odd) begin
                            pair <= iDATA;
                        end

                        if (row_odd && col_odd) begin
                            oDVAL       <= 1'b1;
                            oGRAY       <= quad_sum[DW+1:2];
                            oX          <= qx_out;
                            oY          <= qy_out;
                            oFRAME_DONE <= last_col && last_row;
                        end

                        if (last_col) begin
                            rx <= '0;
                            if (last_row) begin
                                ry    <= '0;
                                state <= ST_DONE;
                            end else begin
                                ry <= ry + 1'b1;
                            end
                        end else begin
                            rx <= rx + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
